uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares the single UART transmit datapath (TX FSM + shift/parity path) between NUM_REQ byte producers.
- Grants one requester at a time and latches its byte.
- Pulses the transmitter's start input, then tracks the transmitter's busy flag through the whole frame before re-arbitrating.
- Sits between the producer blocks (command/status/debug sources) and the TX datapath.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART TX datapath
// between NUM_REQ byte producers. Grants one requester, launches its byte,
// then follows tx_busy through the whole frame before arbitrating again.
// Optional feature: define UART_TX_ARB_BURST_EN to let the granted requester
// send up to BURST_MAX back-to-back bytes without returning to IDLE.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned BURST_MAX     = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_busy,
  output logic                       timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tout_q, tout_d;

`ifdef UART_TX_ARB_BURST_EN
  localparam int unsigned BST_W = $clog2(BURST_MAX + 1);
  localparam logic [BST_W-1:0] BST_LIMIT = BST_W'(BURST_MAX - 1);
  logic [BST_W-1:0]   burst_q, burst_d;
`endif

  logic [DATA_W-1:0]  slot [NUM_REQ];
  logic [ID_W-1:0]    win_id;

  // Unpack the per-requester byte slices.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin winner: first set request scanning last+1, last+2, ... with wrap.
  always_comb begin
    int unsigned idx;
    logic        found;
    win_id = last_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

  // Next-state and datapath-register logic.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tout_d    = 1'b0;
`ifdef UART_TX_ARB_BURST_EN
    burst_d   = burst_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          tx_data_d = slot[win_id];
          grant_d   = win_id;
          last_d    = win_id;
          state_d   = S_LAUNCH;
`ifdef UART_TX_ARB_BURST_EN
          burst_d   = '0;
`endif
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
`ifdef UART_TX_ARB_BURST_EN
          if (req[grant_q] && (burst_q < BST_LIMIT)) begin
            tx_data_d = slot[grant_q];
            burst_d   = burst_q + BST_W'(1);
            state_d   = S_LAUNCH;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      tout_q    <= 1'b0;
`ifdef UART_TX_ARB_BURST_EN
      burst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
`ifdef UART_TX_ARB_BURST_EN
      burst_q   <= burst_d;
`endif
    end
  end

  // tx_start is masked by tx_busy so the transmitter can never be
  // re-triggered while it is still in a frame.
  assign tx_start    = (state_q == S_LAUNCH) && !tx_busy;
  assign ack         = (state_q == S_LAUNCH) ? (NUM_REQ'(1) << grant_q) : '0;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign arb_busy    = (state_q != S_IDLE);
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected grants,
// behavioural transmitter model driving tx_busy.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ST_TO   = 16;

  logic                       clock;
  logic                       reset_n;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         ack;
  logic                       tx_start;
  logic [DATA_W-1:0]          tx_data;
  logic                       tx_busy;
  logic [1:0]                 grant_id;
  logic                       arb_busy;
  logic                       timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .START_TIMEOUT(ST_TO),
    .BURST_MAX    (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          grants_seen = 0;
  logic        hold_req = 1'b0;
  logic        tx_model_en = 1'b1;
  logic [7:0]  cur_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_grant(input int id);
    logic [NUM_REQ*DATA_W-1:0] rd;
    rd = req_data;
    exp_q.push_back('{id: id, data: rd[id*DATA_W +: DATA_W]});
  endtask

  task automatic set_slot(input int id, input logic [7:0] v);
    req_data[id*DATA_W +: DATA_W] = v;
  endtask

  task automatic wait_grants(input int tgt, input int budget);
    for (int i = 0; i < budget && grants_seen < tgt; i++) @(negedge clock);
    check_eq("grants_reached", grants_seen, tgt);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && arb_busy; i++) @(negedge clock);
    check_eq("idle_reached", arb_busy, 0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    req      = '0;
    hold_req = 1'b0;
    repeat (2) @(negedge clock);
    reset_n  = 1'b1;
  endtask

  // Transmitter model: tx_busy rises 2 cycles after start, stays high 11 cycles.
  initial begin
    int dly;
    int len;
    tx_busy = 1'b0;
    dly = 0;
    len = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n || !tx_model_en) begin
        tx_busy = 1'b0;
        dly = 0;
        len = 0;
      end else begin
        if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            tx_busy = 1'b1;
            len = 11;
          end
        end else if (len > 0) begin
          len--;
          if (len == 0) tx_busy = 1'b0;
        end
        if (tx_start && dly == 0 && len == 0) dly = 2;
      end
    end
  end

  // Scoreboard monitor: every launch pops one expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      check_eq("start_while_busy", tx_start & tx_busy, 0);
      if (ack != '0 || tx_start) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ack", ack, 0);
          check_eq("unexpected_start", tx_start, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("grant_id", grant_id, e.id);
          check_eq("ack_onehot", ack, 1 << e.id);
          check_eq("start_with_ack", tx_start, 1);
          check_eq("tx_data_launch", tx_data, e.data);
          cur_data = e.data;
        end
        grants_seen++;
        if (!hold_req) req[grant_id] = 1'b0;
      end
      if (tx_busy) check_eq("tx_data_stable", tx_data, cur_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tgt;
    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Reset state
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_arb_busy", arb_busy, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_grant_id", grant_id, 0);

    // Single request: latency, frame tracking, arb_busy release
    set_slot(0, 8'hA5);
    expect_grant(0);
    req = 4'b0001;
    @(negedge clock);
    check_eq("lat_start", tx_start, 1);
    check_eq("lat_ack", ack, 4'b0001);
    for (int i = 0; i < 10 && !tx_busy; i++) @(negedge clock);
    check_eq("busy_rise", tx_busy, 1);
    check_eq("single_data", tx_data, 8'hA5);
    for (int i = 0; i < 30 && tx_busy; i++) @(negedge clock);
    check_eq("busy_fall", tx_busy, 0);
    check_eq("arb_busy_hold", arb_busy, 1);
    @(negedge clock);
    check_eq("arb_busy_fall", arb_busy, 0);

    // Contention: all four requesting continuously
    apply_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 8'h10 + 8'(i));
    hold_req = 1'b1;
    tgt = grants_seen + 6;
    expect_grant(0); expect_grant(1); expect_grant(2);
    expect_grant(3); expect_grant(0); expect_grant(1);
    req = 4'b1111;
    wait_grants(tgt, 400);
    req = '0;
    hold_req = 1'b0;
    wait_idle(60);

    // Wrap-around: last=2, then 0011 -> 0, then remaining 0010 -> 1
    apply_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 8'h20 + 8'(i));
    tgt = grants_seen + 1;
    expect_grant(2);
    req = 4'b0100;
    wait_grants(tgt, 50);
    wait_idle(60);
    @(negedge clock);
    tgt = grants_seen + 2;
    expect_grant(0); expect_grant(1);
    req = 4'b0011;
    wait_grants(tgt, 100);
    wait_idle(60);

    // Timeout: transmitter never goes busy
    tx_model_en = 1'b0;
    @(negedge clock);
    hold_req = 1'b1;
    expect_grant(2); expect_grant(2);
    req = 4'b0100;
    @(negedge clock);
    check_eq("to_launch", tx_start, 1);
    for (int k = 1; k < ST_TO + 1; k++) begin
      @(negedge clock);
      check_eq("to_early", timeout_err, 0);
    end
    @(negedge clock);
    check_eq("to_pulse", timeout_err, 1);
    check_eq("to_idle", arb_busy, 0);
    @(negedge clock);
    check_eq("to_clear", timeout_err, 0);
    check_eq("to_relaunch", tx_start, 1);
    req = '0;
    hold_req = 1'b0;
    wait_idle(60);
    tx_model_en = 1'b1;
    @(negedge clock);

    // Reset mid-frame: pointer returns to NUM_REQ-1, so requester 0 wins
    tgt = grants_seen + 1;
    expect_grant(1);
    req = 4'b0010;
    wait_grants(tgt, 50);
    for (int i = 0; i < 10 && !tx_busy; i++) @(negedge clock);
    check_eq("mid_busy", tx_busy, 1);
    req = 4'b1001;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_eq("mid_rst_start", tx_start, 0);
    check_eq("mid_rst_ack", ack, 0);
    check_eq("mid_rst_busy", arb_busy, 0);
    check_eq("mid_rst_timeout", timeout_err, 0);
    check_eq("mid_rst_data", tx_data, 0);
    check_eq("mid_rst_grant", grant_id, 0);
    tgt = grants_seen + 2;
    expect_grant(0); expect_grant(3);
    wait_grants(tgt, 100);
    wait_idle(60);

    // Held pair of requests: burst or strict alternation
    apply_reset();
    set_slot(0, 8'h30);
    set_slot(1, 8'h31);
    hold_req = 1'b1;
    tgt = grants_seen + 6;
`ifdef UART_TX_ARB_BURST_EN
    expect_grant(0); expect_grant(0); expect_grant(0);
    expect_grant(0); expect_grant(1); expect_grant(1);
`else
    expect_grant(0); expect_grant(1); expect_grant(0);
    expect_grant(1); expect_grant(0); expect_grant(1);
`endif
    req = 4'b0011;
    wait_grants(tgt, 400);
    req = '0;
    hold_req = 1'b0;
    wait_idle(60);
    repeat (3) @(negedge clock);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
